bti_seq_mst: RTL and testbench
==============================

# bti_seq_mst

BTI initiator that turns one start command into a sequence of single-word BTI requests to consecutive word addresses, then collects and checks the in-order responses. It is the requester counterpart of the BTI-to-SRAM responder and drives `bti_sram`, or any BTI slave, for memory fill, readback and self-test. Write sequences store an incrementing data pattern. Read sequences compare returned data against the same pattern. The block counts errors and reports completion.

## Interface
- `BTI_AW`, 32, BTI address width.
- `BTI_DW`, 32, BTI data width.
- `MAX_OST`, 4, maximum outstanding requests (1..2^`BTI_TIDW`).
- `LENW`, 16, width of the word-count field.
- `clk`  input  1  single clock; every element is synchronous to it.
- `rst`  input  1  synchronous, active-high reset.
- `start_vld`  input  1  start command valid.
- `start_rdy`  output  1  high only in IDLE.
- `start_wr`  input  1  1 = write sequence, 0 = read sequence.
- `start_addr`  input  BTI_AW  byte base address; bits [1:0] are ignored (forced to 0).
- `start_len`  input  LENW  number of words.
- `start_seed`  input  BTI_DW  pattern seed; word i carries/expects `seed + i` (mod 2^BTI_DW).
- `bti_req_mst`  bti_req_if_t.mst  -  request channel: vld, rdy, pkt.{tid, cmd, addr, data}.
- `bti_rsp_slv`  bti_rsp_if_t.slv  -  response channel: vld, rdy, pkt.{tid, data, ok}.
- `busy`  output  1  high in RUN and DRAIN.
- `done`  output  1  one-cycle pulse when the sequence completes.
- `err_cnt`  output  16  saturating error count for the last sequence.

## Operation
- States:
  - IDLE: `start_rdy`=1.
    - Start handshake with len>0 -> RUN.
    - Start handshake with len=0 -> DONE.
  - RUN: issues requests. When the last request handshakes, go to DRAIN. If its response is already the final one in the same cycle, go to DONE.
  - DRAIN: no new requests. When the final response handshakes -> DONE.
  - DONE: `done`=1 for one cycle -> IDLE.
- Start accept latches the command fields and clears the issue index, response index, outstanding counter and `err_cnt`.
- Request fields for issue index i:
  - addr = base + 4*i, wrapping mod 2^BTI_AW.
  - cmd = BTI_CMD_WRITE or BTI_CMD_READ.
  - data = seed + i; it is 0 for reads.
  - tid = i[`BTI_TIDW-1:0].
- `bti_req_mst.vld` = RUN && issued < len && ost < MAX_OST.
  - Once vld is asserted, pkt is held stable until rdy.
  - vld is never withdrawn without a handshake, except on `rst`.
- `ost` is the outstanding counter: +1 on request handshake, -1 on response handshake, net 0 when both occur in the same cycle. It never exceeds MAX_OST and never underflows.
- `bti_rsp_slv.rdy` is tied to 1 at all times. Responses are in request order. Response index j is checked against:
  - ok != 1 -> error.
  - tid != j[`BTI_TIDW-1:0] -> error.
  - Read sequence and data != seed + j -> error.
  - At most one increment per response, even if several checks fail.
- A response handshake in IDLE or DONE is a stray response: it increments `err_cnt` and does not change state.
- `err_cnt` saturates at 0xFFFF. It holds its value after `done` until the next start accept.
- Reset mid-operation: the block returns to IDLE and all counters are cleared. Any in-flight transactions are abandoned; their late responses count as stray errors.

## Timing
- Reset values:
  - `start_rdy`=1.
  - `busy`=0, `done`=0, `err_cnt`=0.
  - `bti_req_mst.vld`=0 and pkt all zero.
  - `bti_rsp_slv.rdy`=1.
- Start accepted in cycle N -> first `req.vld` in N+1.
- With an always-ready slave of 1-cycle response latency, throughput is one request per cycle. Total cycles from accept to `done` = len + 2.
- len=0: `done` in N+1; no BTI traffic; `err_cnt`=0.
- `busy` is high from N+1 through the cycle before DONE. `done` and `busy` are never high together.
- `start_rdy` is low from N+1 until the cycle after `done`.

## Test plan
- Write then read-back on `bti_sram`:
  - Write sequence: addr 0x100, len 8, seed 0xA5A50000 -> SRAM words 0x40..0x47 = 0xA5A50000..0xA5A50007; `done` at N+10; `err_cnt`=0.
  - Read sequence with the same parameters -> `err_cnt`=0.
- Corruption: after the fill, overwrite word 0x43 with 0, then run the read sequence -> `err_cnt`=1.
- Backpressure:
  - Slave holds `req.rdy` low for 5 cycles, then toggles it randomly.
  - Response delay is 0..6 cycles.
  - Required: `ost` never exceeds 4; pkt stable while vld && !rdy; all 32 words are issued exactly once; `err_cnt`=0.
- Address wrap: write, base 0xFFFFFFF8, len 4 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; tids 0, 1, 2, 3.
- len=0: `done` pulses at N+1; no `req.vld`; `start_rdy` back high at N+2.
- Reset mid-run: `rst` asserted after 3 of 8 requests.
  - Next cycle: `req.vld`=0, `busy`=0, `err_cnt`=0.
  - An injected late response increments `err_cnt` to 1.
  - A fresh start clears `err_cnt` to 0.

Source files
------------

// File: rtl/bti_seq_mst.sv
// BTI sequence initiator: issues single-word requests to consecutive word addresses
// carrying an incrementing pattern, then checks the in-order responses and counts errors.
module bti_seq_mst #(
  parameter int unsigned BTI_AW   = 32,
  parameter int unsigned BTI_DW   = 32,
  parameter int unsigned BTI_TIDW = 4,
  parameter int unsigned MAX_OST  = 4,
  parameter int unsigned LENW     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_vld,
  output logic                start_rdy,
  input  logic                start_wr,
  input  logic [BTI_AW-1:0]   start_addr,
  input  logic [LENW-1:0]     start_len,
  input  logic [BTI_DW-1:0]   start_seed,
  output logic                bti_req_mst_vld,
  input  logic                bti_req_mst_rdy,
  output logic [BTI_TIDW-1:0] bti_req_mst_tid,
  output logic                bti_req_mst_cmd,
  output logic [BTI_AW-1:0]   bti_req_mst_addr,
  output logic [BTI_DW-1:0]   bti_req_mst_data,
  input  logic                bti_rsp_slv_vld,
  output logic                bti_rsp_slv_rdy,
  input  logic [BTI_TIDW-1:0] bti_rsp_slv_tid,
  input  logic [BTI_DW-1:0]   bti_rsp_slv_data,
  input  logic                bti_rsp_slv_ok,
  output logic                busy,
  output logic                done,
  output logic [15:0]         err_cnt
);

  localparam int unsigned OSTW = $clog2(MAX_OST + 1);
  localparam int unsigned ERRW = 16;
  localparam logic BTI_CMD_READ  = 1'b0;
  localparam logic BTI_CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e                state_q;
  logic                  wr_q;
  logic [BTI_AW-1:0]     base_q;
  logic [BTI_DW-1:0]     seed_q;
  logic [LENW-1:0]       len_q;
  logic [LENW-1:0]       iss_q;
  logic [LENW-1:0]       rsp_q;
  logic [OSTW-1:0]       ost_q;
  logic [ERRW-1:0]       err_q;
  logic                  vld_q;
  logic [BTI_TIDW-1:0]   tid_q;
  logic                  cmd_q;
  logic [BTI_AW-1:0]     addr_q;
  logic [BTI_DW-1:0]     data_q;
  logic                  start_rdy_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  in_seq;
  logic                  req_hs;
  logic                  rsp_hs;
  logic                  rsp_dec;
  logic [LENW-1:0]       iss_d;
  logic [OSTW-1:0]       ost_d;
  logic [LENW-1:0]       last_idx;
  logic                  last_req;
  logic                  last_rsp;
  logic [BTI_DW-1:0]     exp_data;
  logic                  rsp_bad;
  logic                  err_inc;
  logic                  vld_d;
  logic [BTI_AW-1:0]     addr_d;
  logic [BTI_DW-1:0]     data_d;
  logic [BTI_AW-1:0]     start_base;

  // Handshake decode, next issue/outstanding values and response checking
  always_comb begin
    in_seq     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    req_hs     = vld_q && bti_req_mst_rdy;
    rsp_hs     = bti_rsp_slv_vld;
    rsp_dec    = rsp_hs && in_seq && ((ost_q != '0) || req_hs);
    iss_d      = iss_q + LENW'(req_hs);
    ost_d      = ost_q + OSTW'(req_hs) - OSTW'(rsp_dec);
    last_idx   = len_q - LENW'(1);
    last_req   = req_hs && (iss_q == last_idx);
    last_rsp   = rsp_hs && in_seq && (rsp_q == last_idx);
    exp_data   = seed_q + BTI_DW'(rsp_q);
    rsp_bad    = !bti_rsp_slv_ok
              || (bti_rsp_slv_tid != rsp_q[BTI_TIDW-1:0])
              || (!wr_q && (bti_rsp_slv_data != exp_data));
    err_inc    = rsp_hs && (!in_seq || rsp_bad);
    vld_d      = (iss_d < len_q) && (ost_d < OSTW'(MAX_OST));
    addr_d     = base_q + (BTI_AW'(iss_d) << 2);
    data_d     = wr_q ? (seed_q + BTI_DW'(iss_d)) : '0;
    start_base = start_addr & ~BTI_AW'(3);
  end

  // Sequencer state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      base_q      <= '0;
      seed_q      <= '0;
      len_q       <= '0;
      iss_q       <= '0;
      rsp_q       <= '0;
      ost_q       <= '0;
      err_q       <= '0;
      vld_q       <= 1'b0;
      tid_q       <= '0;
      cmd_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      start_rdy_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      iss_q  <= iss_d;
      ost_q  <= ost_d;
      if (err_inc && (err_q != '1)) err_q <= err_q + ERRW'(1);
      if (rsp_hs && in_seq) rsp_q <= rsp_q + LENW'(1);
      case (state_q)
        ST_IDLE: begin
          if (start_vld) begin
            wr_q        <= start_wr;
            base_q      <= start_base;
            seed_q      <= start_seed;
            len_q       <= start_len;
            iss_q       <= '0;
            rsp_q       <= '0;
            ost_q       <= '0;
            err_q       <= '0;
            start_rdy_q <= 1'b0;
            if (start_len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              vld_q   <= 1'b1;
              tid_q   <= '0;
              cmd_q   <= start_wr ? BTI_CMD_WRITE : BTI_CMD_READ;
              addr_q  <= start_base;
              data_q  <= start_wr ? start_seed : '0;
            end
          end
        end
        ST_RUN: begin
          // pkt only moves after a handshake because iss_d holds otherwise
          vld_q  <= vld_d;
          tid_q  <= iss_d[BTI_TIDW-1:0];
          addr_q <= addr_d;
          data_q <= data_d;
          if (last_req) begin
            if (last_rsp) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (last_rsp) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          start_rdy_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          start_rdy_q <= 1'b1;
          busy_q      <= 1'b0;
          vld_q       <= 1'b0;
        end
      endcase
    end
  end

  assign start_rdy        = start_rdy_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err_cnt          = err_q;
  assign bti_req_mst_vld  = vld_q;
  assign bti_req_mst_tid  = tid_q;
  assign bti_req_mst_cmd  = cmd_q;
  assign bti_req_mst_addr = addr_q;
  assign bti_req_mst_data = data_q;
  assign bti_rsp_slv_rdy  = 1'b1;

endmodule

// File: tb/tb_bti_seq_mst.sv
// Randomized bench for bti_seq_mst: a BTI memory slave with backpressure, response delay
// and fault injection, checked against a per-word sequence model of requests and errors.
module tb_bti_seq_mst;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_vld = 1'b0;
  logic        start_rdy;
  logic        start_wr = 1'b0;
  logic [31:0] start_addr = '0;
  logic [15:0] start_len = '0;
  logic [31:0] start_seed = '0;
  logic        req_vld;
  logic        req_rdy = 1'b0;
  logic [3:0]  req_tid;
  logic        req_cmd;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_vld = 1'b0;
  logic        rsp_rdy;
  logic [3:0]  rsp_tid = '0;
  logic [31:0] rsp_data = '0;
  logic        rsp_ok = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] err_cnt;

  bti_seq_mst #(.BTI_AW(32), .BTI_DW(32), .BTI_TIDW(4), .MAX_OST(4), .LENW(16)) dut (
    .clk(clk), .rst(rst),
    .start_vld(start_vld), .start_rdy(start_rdy), .start_wr(start_wr),
    .start_addr(start_addr), .start_len(start_len), .start_seed(start_seed),
    .bti_req_mst_vld(req_vld), .bti_req_mst_rdy(req_rdy), .bti_req_mst_tid(req_tid),
    .bti_req_mst_cmd(req_cmd), .bti_req_mst_addr(req_addr), .bti_req_mst_data(req_data),
    .bti_rsp_slv_vld(rsp_vld), .bti_rsp_slv_rdy(rsp_rdy), .bti_rsp_slv_tid(rsp_tid),
    .bti_rsp_slv_data(rsp_data), .bti_rsp_slv_ok(rsp_ok),
    .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic cmd; logic [31:0] addr; logic [31:0] data; logic [3:0] tid; } req_t;
  typedef struct packed { logic [3:0] tid; logic [31:0] data; logic ok; int due; } rsp_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [31:0] mem [logic [31:0]];
  req_t        exp_q[$];
  rsp_t        rq[$];
  logic [31:0] obs_addr[$];
  logic [3:0]  obs_tid[$];
  bit          fault_a[$];

  int rdy_mode = 0;   // 0 always ready, 1 random after rdy_hold, 2 ready until hs_limit
  int rdy_hold = 0;
  int hs_limit = 0;
  int dly_max = 0;
  int fault_pct = 0;
  bit hold_rsp = 0;
  bit inject = 0;
  int hs_cnt = 0, req_bad = 0, stab_bad = 0, ost_tb = 0, ost_max = 0;
  int bd_bad = 0, srdy_bad = 0, rrdy_bad = 0, vld_seen = 0, first_vld = -1;
  bit prev_pend = 0;
  req_t prev_pkt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] w);
    return mem.exists(w) ? mem[w] : 32'h0;
  endfunction

  // Slave and protocol monitors, evaluated once per cycle away from the active edge
  task automatic slave_step();
    req_t cur;
    req_t e;
    rsp_t r;
    cur = '{cmd: req_cmd, addr: req_addr, data: req_data, tid: req_tid};
    if (busy && done) bd_bad++;
    if (start_rdy !== !(busy || done)) srdy_bad++;
    if (rsp_rdy !== 1'b1) rrdy_bad++;
    if (prev_pend && !rst && (!req_vld || cur != prev_pkt)) stab_bad++;
    if (req_vld) begin
      vld_seen++;
      if (first_vld < 0) first_vld = cyc;
    end
    rsp_vld = 1'b0;
    if (inject) begin
      rsp_vld = 1'b1; rsp_tid = 4'h0; rsp_data = 32'h0; rsp_ok = 1'b1;
      inject = 0;
    end else if (!hold_rsp && rq.size() > 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      rsp_vld = 1'b1; rsp_tid = r.tid; rsp_data = r.data; rsp_ok = r.ok;
      ost_tb--;
    end
    case (rdy_mode)
      1: begin
        req_rdy = (rdy_hold > 0) ? 1'b0 : 1'($urandom_range(0, 1));
        if (rdy_hold > 0) rdy_hold--;
      end
      2: req_rdy = (hs_cnt < hs_limit);
      default: req_rdy = 1'b1;
    endcase
    if (req_vld && req_rdy) begin
      if (hs_cnt < exp_q.size()) begin
        e = exp_q[hs_cnt];
        if (cur != e) req_bad++;
      end else begin
        req_bad++;
      end
      obs_addr.push_back(req_addr);
      obs_tid.push_back(req_tid);
      r.tid = req_tid;
      r.ok = 1'b1;
      if (req_cmd) begin
        mem[req_addr >> 2] = req_data;
        r.data = 32'h0;
      end else begin
        r.data = mem_rd(req_addr >> 2);
      end
      if (int'($urandom_range(0, 99)) < fault_pct) begin
        fault_a.push_back(1'b1);
        if ($urandom_range(0, 1) == 1) r.ok = 1'b0;
        else r.tid = r.tid ^ 4'h1;
      end else begin
        fault_a.push_back(1'b0);
      end
      r.due = cyc + 1 + int'($urandom_range(0, dly_max));
      rq.push_back(r);
      hs_cnt++;
      ost_tb++;
    end
    if (ost_tb > ost_max) ost_max = ost_tb;
    prev_pend = req_vld && !req_rdy;
    prev_pkt = cur;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    slave_step();
  endtask

  // Runs one start command to completion and checks it against the sequence model
  task automatic run_seq(input bit wr, input logic [31:0] addr, input int len,
                         input logic [31:0] seed, output int lat);
    logic [31:0] base;
    logic [31:0] snap[$];
    int n0, k, exp_err;
    base = addr & ~32'h3;
    exp_q.delete(); snap.delete(); fault_a.delete(); obs_addr.delete(); obs_tid.delete();
    for (int i = 0; i < len; i++) begin
      exp_q.push_back('{cmd: wr, addr: base + 32'(4 * i),
                        data: wr ? seed + 32'(i) : 32'h0, tid: 4'(i)});
      snap.push_back(mem_rd((base + 32'(4 * i)) >> 2));
    end
    hs_cnt = 0; req_bad = 0; ost_max = 0; first_vld = -1;
    k = 0;
    while (!start_rdy && k < 100) begin tick(); k++; end
    chk("start_rdy_wait", start_rdy, 1);
    start_wr = wr; start_addr = addr; start_len = 16'(len); start_seed = seed;
    start_vld = 1'b1;
    n0 = cyc;
    tick();
    start_vld = 1'b0;
    chk("err_clear", err_cnt, 0);
    k = 0;
    while (!done && k < 3000) begin tick(); k++; end
    chk("done_seen", done, 1);
    lat = cyc - n0;
    tick();
    chk("start_rdy_back", start_rdy, 1);
    exp_err = 0;
    for (int i = 0; i < len; i++)
      if (fault_a[i] || (!wr && snap[i] != seed + 32'(i))) exp_err++;
    chk("issue_count", hs_cnt, len);
    chk("req_fields", req_bad, 0);
    chk("err_model", err_cnt, exp_err);
    if (len > 0) chk("first_vld_lat", first_vld - n0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, v0, k;
    logic [31:0] a;
    repeat (3) tick();
    chk("rst_start_rdy", start_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_vld", req_vld, 0);
    chk("rst_pkt", {req_tid, req_cmd, req_addr, req_data}, 0);
    chk("rst_rsp_rdy", rsp_rdy, 1);
    rst = 1'b0;
    tick();

    // Fill then readback with an always-ready slave of one-cycle latency
    run_seq(1'b1, 32'h100, 8, 32'hA5A50000, lat);
    chk("fill_lat", lat, 10);
    for (int i = 0; i < 8; i++) chk("fill_mem", mem_rd(32'h40 + 32'(i)), 32'hA5A50000 + 32'(i));
    chk("fill_err", err_cnt, 0);
    run_seq(1'b0, 32'h100, 8, 32'hA5A50000, lat);
    chk("read_lat", lat, 10);
    chk("read_err", err_cnt, 0);

    mem[32'h43] = 32'h0;
    run_seq(1'b0, 32'h100, 8, 32'hA5A50000, lat);
    chk("corrupt_err", err_cnt, 1);

    // Backpressure and random response delay
    rdy_mode = 1; rdy_hold = 5; dly_max = 6;
    run_seq(1'b1, 32'h800, 32, 32'h0BAD0000, lat);
    chk("bp_wr_ost_max", ost_max <= 4, 1);
    chk("bp_wr_err", err_cnt, 0);
    rdy_hold = 5;
    run_seq(1'b0, 32'h800, 32, 32'h0BAD0000, lat);
    chk("bp_rd_ost_max", ost_max <= 4, 1);
    chk("bp_rd_err", err_cnt, 0);
    chk("bp_issued", hs_cnt, 32);

    // Address wrap
    rdy_mode = 0; dly_max = 0;
    run_seq(1'b1, 32'hFFFFFFF8, 4, 32'h11110000, lat);
    chk("wrap_a0", obs_addr[0], 32'hFFFFFFF8);
    chk("wrap_a1", obs_addr[1], 32'hFFFFFFFC);
    chk("wrap_a2", obs_addr[2], 32'h0);
    chk("wrap_a3", obs_addr[3], 32'h4);
    chk("wrap_tids", {obs_tid[0], obs_tid[1], obs_tid[2], obs_tid[3]}, 16'h0123);

    // Zero length
    v0 = vld_seen;
    run_seq(1'b1, 32'h40, 0, 32'h0, lat);
    chk("len0_lat", lat, 1);
    chk("len0_no_vld", vld_seen - v0, 0);
    chk("len0_err", err_cnt, 0);

    // Reset mid-run, late stray response, fresh start
    rdy_mode = 2; hs_limit = 3; hold_rsp = 1;
    hs_cnt = 0; exp_q.delete();
    start_wr = 1'b1; start_addr = 32'h200; start_len = 16'd8; start_seed = 32'h5;
    start_vld = 1'b1;
    tick();
    start_vld = 1'b0;
    k = 0;
    while (hs_cnt < 3 && k < 100) begin tick(); k++; end
    chk("mid_hs3", hs_cnt, 3);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_vld", req_vld, 0);
    chk("mid_busy", busy, 0);
    chk("mid_err", err_cnt, 0);
    rst = 1'b0;
    rq.delete(); ost_tb = 0; prev_pend = 0; hold_rsp = 0; rdy_mode = 0;
    inject = 1;
    tick();
    tick();
    chk("stray_err", err_cnt, 1);
    chk("stray_idle", start_rdy, 1);
    run_seq(1'b1, 32'h300, 2, 32'h1234, lat);
    chk("fresh_err", err_cnt, 0);

    // Randomized sequences with faults
    rdy_mode = 1; dly_max = 6; fault_pct = 20;
    for (int t = 0; t < 8; t++) begin
      rdy_hold = int'($urandom_range(0, 3));
      a = 32'h1000 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      run_seq(1'($urandom_range(0, 1)), a, int'($urandom_range(1, 24)), $urandom, lat);
      chk("rnd_ost_max", ost_max <= 4, 1);
    end

    chk("busy_done_excl", bd_bad, 0);
    chk("start_rdy_state", srdy_bad, 0);
    chk("rsp_rdy_tied", rrdy_bad, 0);
    chk("pkt_stable", stab_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
